// File: rtl/pio_host_master.sv
// pio_host_master: host command initiator for the PIO action/config interface.
// Optional boot-image replay from an external ROM when BOOT_ROM_EN is defined.
module pio_host_master #(
    parameter int BOOT_AW       = 6,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [3:0]         cmd_action,
    input  logic [1:0]         cmd_mindex,
    input  logic [4:0]         cmd_index,
    input  logic [31:0]        cmd_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [31:0]        rsp_data,
    output logic               rsp_err,
    output logic [3:0]         pio_action,
    output logic [1:0]         pio_mindex,
    output logic [4:0]         pio_index,
    output logic [31:0]        pio_din,
    input  logic [31:0]        pio_dout,
    input  logic [3:0]         pio_tx_full,
    input  logic [3:0]         pio_rx_empty,
    output logic [BOOT_AW-1:0] boot_addr,
    input  logic [43:0]        boot_data,
    output logic               boot_done
);
    localparam logic [3:0] ACT_PULL = 4'd3;
    localparam logic [3:0] ACT_PUSH = 4'd4;
    localparam int SW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        BOOT_RD, BOOT_ISSUE, IDLE, WAIT, ISSUE, CAPTURE, SETTLE, RSP
    } state_t;

    function automatic logic act_is_valid(input logic [3:0] a);
        return (a != 4'd0) && (a <= 4'd10);
    endfunction

    state_t        state_reg, state_next, done_state;
    logic [3:0]    act_reg;
    logic [1:0]    mindex_reg;
    logic [4:0]    index_reg;
    logic [31:0]   data_reg;
    logic [SW-1:0] settle_cnt_reg;
    logic          accept, act_ok, flow_ok, booting, at_end;
    logic          cmd_ready_next, rsp_valid_next, rsp_err_next, boot_done_next;
    logic [31:0]   rsp_data_next, pio_din_next;
    logic [3:0]    pio_action_next;
    logic [1:0]    pio_mindex_next;
    logic [4:0]    pio_index_next;

`ifdef BOOT_ROM_EN
    localparam state_t RESET_STATE = BOOT_RD;
    logic last_reg;
    logic boot_act_ok, boot_at_end;

    assign booting        = !boot_done;
    assign at_end         = last_reg || (boot_addr == {BOOT_AW{1'b1}});
    assign boot_act_ok    = act_is_valid(boot_data[42:39]);
    assign boot_at_end    = boot_data[43] || (boot_addr == {BOOT_AW{1'b1}});
    assign boot_done_next = boot_done || (state_next == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            boot_addr <= '0;
            last_reg  <= 1'b0;
        end else begin
            if (state_next == BOOT_RD)
                boot_addr <= boot_addr + 1'b1;
            if (state_reg == BOOT_ISSUE)
                last_reg <= boot_data[43];
        end
    end
`else
    localparam state_t RESET_STATE = IDLE;
    logic unused_boot;

    assign booting        = 1'b0;
    assign at_end         = 1'b1;
    assign boot_done_next = 1'b1;
    assign boot_addr      = '0;
    assign unused_boot    = ^boot_data;
`endif

    assign accept  = (state_reg == IDLE) && cmd_valid && cmd_ready;
    assign act_ok  = act_is_valid(act_reg);
    assign flow_ok = (act_reg == ACT_PUSH) ? !pio_tx_full[mindex_reg] :
                     (act_reg == ACT_PULL) ? !pio_rx_empty[mindex_reg] : 1'b1;
    // Boot entries chain straight into the next ROM read instead of a host response.
    assign done_state = booting ? (at_end ? IDLE : BOOT_RD) : RSP;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= RESET_STATE;
            act_reg        <= '0;
            mindex_reg     <= '0;
            index_reg      <= '0;
            data_reg       <= '0;
            settle_cnt_reg <= '0;
            cmd_ready      <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_data       <= '0;
            rsp_err        <= 1'b0;
            pio_action     <= '0;
            pio_mindex     <= '0;
            pio_index      <= '0;
            pio_din        <= '0;
            boot_done      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= (state_reg == SETTLE) ? settle_cnt_reg + 1'b1 : '0;
            if (accept) begin
                act_reg    <= cmd_action;
                mindex_reg <= cmd_mindex;
                index_reg  <= cmd_index;
                data_reg   <= cmd_data;
            end
`ifdef BOOT_ROM_EN
            else if (state_reg == BOOT_ISSUE) begin
                act_reg    <= boot_data[42:39];
                mindex_reg <= boot_data[38:37];
                index_reg  <= boot_data[36:32];
                data_reg   <= boot_data[31:0];
            end
`endif
            cmd_ready  <= cmd_ready_next;
            rsp_valid  <= rsp_valid_next;
            rsp_data   <= rsp_data_next;
            rsp_err    <= rsp_err_next;
            pio_action <= pio_action_next;
            pio_mindex <= pio_mindex_next;
            pio_index  <= pio_index_next;
            pio_din    <= pio_din_next;
            boot_done  <= boot_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
`ifdef BOOT_ROM_EN
            BOOT_RD:    state_next = BOOT_ISSUE;
            BOOT_ISSUE: begin
                if (boot_act_ok)
                    state_next = WAIT;
                else
                    state_next = boot_at_end ? IDLE : BOOT_RD;
            end
`endif
            IDLE:    if (accept) state_next = WAIT;
            WAIT: begin
                if (!act_ok)
                    state_next = RSP;
                else if (flow_ok)
                    state_next = ISSUE;
            end
            ISSUE: begin
                if (act_reg == ACT_PULL)
                    state_next = CAPTURE;
                else if (act_reg == ACT_PUSH && SETTLE_CYCLES > 0)
                    state_next = SETTLE;
                else
                    state_next = done_state;
            end
            CAPTURE: state_next = (SETTLE_CYCLES > 0) ? SETTLE : done_state;
            SETTLE:  if (settle_cnt_reg == SW'(SETTLE_CYCLES - 1)) state_next = done_state;
            RSP:     if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output values are computed against state_next so the registered copy lines up with the state.
    always_comb begin
        cmd_ready_next  = (state_next == IDLE);
        rsp_valid_next  = (state_next == RSP);
        pio_action_next = 4'd0;
        pio_mindex_next = pio_mindex;
        pio_index_next  = pio_index;
        pio_din_next    = pio_din;
        rsp_data_next   = rsp_data;
        rsp_err_next    = rsp_err;
        if (state_next == ISSUE) begin
            pio_action_next = act_reg;
            pio_mindex_next = mindex_reg;
            pio_index_next  = index_reg;
            pio_din_next    = data_reg;
        end
        if (accept) begin
            rsp_data_next = '0;
            rsp_err_next  = 1'b0;
        end
        if (state_reg == CAPTURE && !booting)
            rsp_data_next = pio_dout;
        if (state_reg == WAIT && !act_ok)
            rsp_err_next = 1'b1;
    end
endmodule
